// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, ALU op
// encodings and FSM states.
package calc_pkg;

  localparam logic [5:0] KEY_PLUS  = 6'd10;
  localparam logic [5:0] KEY_MINUS = 6'd11;
  localparam logic [5:0] KEY_EQ    = 6'd12;
  localparam logic [5:0] KEY_MUL   = 6'd13;
  localparam logic [5:0] KEY_CLR   = 6'd14;
  localparam logic [5:0] KEY_DIV   = 6'd15;
  localparam logic [5:0] KEY_NONE  = 6'd16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_REQ, S_WAIT, S_RES} state_t;

  // True for the four arithmetic operator keys.
  function automatic logic is_op_key(input logic [5:0] k);
    return (k == KEY_PLUS) || (k == KEY_MINUS) || (k == KEY_MUL) || (k == KEY_DIV);
  endfunction

  // Map an operator key onto the ALU op_sel encoding.
  function automatic logic [1:0] key_to_op(input logic [5:0] k);
    case (k)
      KEY_MINUS: return OP_SUB;
      KEY_MUL:   return OP_MUL;
      KEY_DIV:   return OP_DIV;
      default:   return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/key_event_sync.sv
// Key front end: 2-flop synchronizer, two-sample stability filter and a
// press detector that fires once when the stable code leaves KEY_NONE.
module key_event_sync
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] key_code,
  output logic       ev,
  output logic [5:0] ev_code
);

  logic [5:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, stable_q, stable_d;
  logic       accept;

  // Next-state for the sync chain and the stable-code filter; press detect.
  always_comb begin
    sync1_d  = key_code;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    accept   = (sync2_q == prev_q);
    stable_d = accept ? sync2_q : stable_q;
    // Only a release-to-valid-key transition counts; codes above NONE never fire.
    ev       = accept && (stable_q == KEY_NONE) && (sync2_q < KEY_NONE);
    ev_code  = sync2_q;
  end

  // Registers; everything resets to "no key" so reset never produces a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= KEY_NONE;
      sync2_q  <= KEY_NONE;
      prev_q   <= KEY_NONE;
      stable_q <= KEY_NONE;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: builds decimal operands from key presses, issues
// one ALU request per '=' and holds the display value.
// Optional feature: define CALC_CHAIN_EN to let an operator pressed on a shown
// result reuse that result as operand A.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   key_code,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [1:0]   op_sel,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  input  logic         res_err,
  output logic [W-1:0] disp_value,
  output logic         disp_err,
  output logic         busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic       ev;
  logic [5:0] ev_code;

  key_event_sync u_key (.clk(clk), .rst(rst), .key_code(key_code), .ev(ev), .ev_code(ev_code));

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d, op_a_q, op_a_d, op_b_q, op_b_d, disp_q, disp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_sel_q, op_sel_d;
  logic           disp_err_q, disp_err_d, clr_pend_q, clr_pend_d;

  logic           is_dig, is_opk, is_eq, is_clr, go_idle;
  logic [3:0]     dval;
  logic [W-1:0]   acc_dig;
  logic [CW-1:0]  cnt_dig;

  // Key decode and the candidate accumulator after a digit press.
  always_comb begin
    is_dig  = ev && (ev_code < 6'd10);
    is_opk  = ev && is_op_key(ev_code);
    is_eq   = ev && (ev_code == KEY_EQ);
    is_clr  = ev && (ev_code == KEY_CLR);
    dval    = ev_code[3:0];
    acc_dig = acc_q;
    cnt_dig = cnt_q;
    // Full operand swallows digits; leading zeros do not consume a digit slot.
    if ((cnt_q != CW'(MAX_DIGITS)) && !((dval == 4'd0) && (acc_q == '0))) begin
      acc_dig = acc_q * W'(10) + W'(dval);
      cnt_dig = cnt_q + CW'(1);
    end
  end

  // Sequencer next-state and register updates.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    disp_d     = disp_q;
    disp_err_d = disp_err_q;
    clr_pend_d = clr_pend_q;
    go_idle    = 1'b0;
    case (state_q)
      S_A: begin
        if (is_clr) go_idle = 1'b1;
        else if (is_dig) begin
          acc_d = acc_dig; cnt_d = cnt_dig; disp_d = acc_dig;
        end else if (is_opk) begin
          op_a_d = acc_q; op_sel_d = key_to_op(ev_code);
          acc_d = '0; cnt_d = '0; state_d = S_OP;
        end
      end
      S_OP: begin
        if (is_clr) go_idle = 1'b1;
        else if (is_dig) begin
          acc_d = acc_dig; cnt_d = cnt_dig; disp_d = acc_dig; state_d = S_B;
        end else if (is_opk) op_sel_d = key_to_op(ev_code);
      end
      S_B: begin
        if (is_clr) go_idle = 1'b1;
        else if (is_dig) begin
          acc_d = acc_dig; cnt_d = cnt_dig; disp_d = acc_dig;
        end else if (is_eq) begin
          op_b_d = acc_q; state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Request is never withdrawn; a clear only takes effect after the result.
        if (is_clr) clr_pend_d = 1'b1;
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (is_clr) clr_pend_d = 1'b1;
        if (res_valid) begin
          if (clr_pend_q || is_clr) go_idle = 1'b1;
          else begin
            disp_d = res_data; disp_err_d = res_err; state_d = S_RES;
          end
        end
      end
      S_RES: begin
        if (is_clr) go_idle = 1'b1;
        else if (is_dig) begin
          acc_d      = W'(dval);
          cnt_d      = (dval == 4'd0) ? '0 : CW'(1);
          disp_d     = W'(dval);
          disp_err_d = 1'b0;
          state_d    = S_A;
        end
`ifdef CALC_CHAIN_EN
        else if (is_opk && !disp_err_q) begin
          op_a_d = disp_q; op_sel_d = key_to_op(ev_code);
          acc_d = '0; cnt_d = '0; state_d = S_OP;
        end
`endif
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_d    = S_A;
      acc_d      = '0;
      cnt_d      = '0;
      op_a_d     = '0;
      op_b_d     = '0;
      op_sel_d   = OP_ADD;
      disp_d     = '0;
      disp_err_d = 1'b0;
      clr_pend_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= OP_ADD;
      disp_q     <= '0;
      disp_err_q <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      disp_q     <= disp_d;
      disp_err_q <= disp_err_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign req_valid  = (state_q == S_REQ);
  assign busy       = (state_q == S_REQ) || (state_q == S_WAIT);
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_sel     = op_sel_q;
  assign disp_value = disp_q;
  assign disp_err   = disp_err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer; expected ALU requests are queued as
// '=' is pressed and compared when the request appears.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   key_code;
  logic         req_valid, req_ready;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   op_sel;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_err;
  logic [W-1:0] disp_value;
  logic         disp_err, busy;

  calc_key_sequencer #(.W(W), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .key_code(key_code),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .disp_value(disp_value), .disp_err(disp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   s;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [5:0] k);
    key_code = k; cyc(6);
    key_code = KEY_NONE; cyc(6);
  endtask

  task automatic result(input logic [W-1:0] d, input logic e);
    res_data = d; res_err = e; res_valid = 1'b1; cyc(1);
    res_valid = 1'b0; cyc(1);
  endtask

  task automatic expect_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    req_t r;
    r.a = a; r.b = b; r.s = s;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for a request, hold ready low for 'hold' cycles checking
  // stability, then accept it and compare against the queued expectation.
  task automatic serve(input string tag, input int hold);
    req_t e;
    int   n = 0;
    while (!req_valid && n < 40) begin cyc(1); n++; end
    check({tag, "_valid"}, req_valid, 1);
    check({tag, "_queued"}, exp_q.size() > 0, 1);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, req_valid, 1);
      check({tag, "_hold_a"}, op_a, e.a);
      check({tag, "_hold_b"}, op_b, e.b);
      cyc(1);
    end
    check({tag, "_op_a"}, op_a, e.a);
    check({tag, "_op_b"}, op_b, e.b);
    check({tag, "_op_sel"}, op_sel, e.s);
    req_ready = 1'b1; cyc(1);
    check({tag, "_valid_drop"}, req_valid, 0);
    check({tag, "_busy_wait"}, busy, 1);
  endtask

  task automatic no_req(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (req_valid) seen = 1'b1;
      cyc(1);
    end
    check({tag, "_no_request"}, seen, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; key_code = KEY_NONE; req_ready = 1'b0;
    res_valid = 1'b0; res_data = '0; res_err = 1'b0;
    cyc(3);
    check("rst_disp", disp_value, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_disp_err", disp_err, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_sel", op_sel, 0);
    rst = 1'b0; cyc(2);

    // 12 + 3 = 15 with ready tied high
    req_ready = 1'b1;
    press(6'd1);  check("t1_d1", disp_value, 1);
    press(6'd2);  check("t1_d12", disp_value, 12);
    press(KEY_PLUS); check("t1_plus_disp", disp_value, 12);
    press(6'd3);  check("t1_d3", disp_value, 3);
    expect_req(16'd12, 16'd3, OP_ADD);
    key_code = KEY_EQ; serve("t1", 0); key_code = KEY_NONE; cyc(6);
    check("t1_busy_wait", busy, 1);
    result(16'd15, 1'b0);
    check("t1_res_disp", disp_value, 15);
    check("t1_res_busy", busy, 0);
    check("t1_res_err", disp_err, 0);

    // operator on a displayed result
    press(KEY_MUL);
    check("t6_mul_disp", disp_value, 15);
    check("t6_mul_busy", busy, 0);
    press(6'd2); check("t6_d2", disp_value, 2);
`ifdef CALC_CHAIN_EN
    expect_req(16'd15, 16'd2, OP_MUL);
    key_code = KEY_EQ; serve("t6", 0); key_code = KEY_NONE; cyc(6);
    result(16'd30, 1'b0);
    check("t6_chain_res", disp_value, 30);
`else
    key_code = KEY_EQ; no_req("t6_eq_in_a", 12); key_code = KEY_NONE; cyc(6);
    check("t6_nochain_busy", busy, 0);
`endif
    press(KEY_CLR);
    check("clr_disp", disp_value, 0);
    check("clr_op_a", op_a, 0);
    check("clr_op_sel", op_sel, 0);

    // digit limit and leading zeros
    for (int i = 0; i < 4; i++) press(6'd9);
    check("t2_9999", disp_value, 9999);
    press(6'd9); check("t2_fifth_ignored", disp_value, 9999);
    press(KEY_CLR);
    press(6'd0); press(6'd0); press(6'd7);
    check("t2_lead0_7", disp_value, 7);
    press(6'd1); press(6'd2); press(6'd3);
    check("t2_7123", disp_value, 7123);
    press(6'd4); check("t2_limit_7123", disp_value, 7123);

    // held key and glitching input
    press(KEY_CLR);
    key_code = 6'd5; cyc(200);
    check("t3_held_once", disp_value, 5);
    key_code = KEY_NONE; cyc(6);
    check("t3_release", disp_value, 5);
    press(KEY_CLR);
    for (int i = 0; i < 40; i++) begin
      key_code = (i % 2 == 0) ? 6'd3 : KEY_NONE;
      cyc(1);
    end
    key_code = KEY_NONE; cyc(8);
    check("t3_glitch_no_event", disp_value, 0);

    // divide by zero with backpressure
    press(KEY_CLR);
    req_ready = 1'b0;
    press(6'd8); press(KEY_DIV); press(6'd0);
    check("t4_b_zero", disp_value, 0);
    expect_req(16'd8, 16'd0, OP_DIV);
    key_code = KEY_EQ; serve("t4", 5); key_code = KEY_NONE; cyc(6);
    result(16'd0, 1'b1);
    check("t4_disp_err", disp_err, 1);
    check("t4_busy", busy, 0);
    press(KEY_PLUS);
    check("t4_op_on_err_ignored", disp_err, 1);
    check("t4_op_on_err_busy", busy, 0);
    press(6'd4);
    check("t4_fresh_digit", disp_value, 4);
    check("t4_err_cleared", disp_err, 0);

    // clear while waiting for the ALU
    press(KEY_CLR);
    press(6'd5); press(KEY_MINUS); press(6'd2);
    expect_req(16'd5, 16'd2, OP_SUB);
    key_code = KEY_EQ; serve("t5", 0); key_code = KEY_NONE; cyc(6);
    press(KEY_CLR);
    check("t5_busy_pending", busy, 1);
    check("t5_disp_pending", disp_value, 2);
    result(16'd42, 1'b0);
    check("t5_discard_disp", disp_value, 0);
    check("t5_busy", busy, 0);
    check("t5_op_a", op_a, 0);
    check("t5_op_sel", op_sel, 0);
    no_req("t5", 20);
    press(6'd3); check("t5_state_a", disp_value, 3);
    result(16'd99, 1'b0);
    check("t5_stray_result", disp_value, 3);

    // reset while a request is pending
    press(KEY_CLR);
    req_ready = 1'b0;
    press(6'd1); press(KEY_PLUS); press(6'd1);
    key_code = KEY_EQ;
    n = 0;
    while (!req_valid && n < 40) begin cyc(1); n++; end
    check("rst_mid_valid", req_valid, 1);
    rst = 1'b1; cyc(1);
    check("rst_mid_drop", req_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_disp", disp_value, 0);
    rst = 1'b0; key_code = KEY_NONE; cyc(8);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
